// File: rtl/sram_responder.sv
// sram_responder -- on-chip stand-in for the off-chip pixel SRAM.
//
// It serves a single-port SRAM-style bus from an internal word array that is
// mapped at BASE_ADDR..BASE_ADDR+DEPTH-1. Reads return data after READ_LAT
// cycles and may be issued back-to-back. A one-cycle mem_clr pulse starts a
// sequencer that zeroes the whole array, one word per cycle. Rejected
// requests raise an error pulse and a sticky error flag.
//
// Optional build macro: SRAM_RESP_STATS_EN enables the saturating read and
// write counters. Without it, rd_count and wr_count are tied to zero.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   read_enable  read request, sampled every rising edge
//   write_enable write request, sampled every rising edge
//   address      request address (ADDR_W)
//   w_data       write data (DATA_W)
//   mem_clr      single-cycle request to zero the whole array
//   r_data       read data, forced to 0 whenever r_valid is 0
//   r_valid      one-cycle strobe per completed read
//   busy         high while the clear sequencer runs
//   error        one-cycle pulse per rejected access
//   err_sticky   latched error, cleared only by reset
//   rd_count     completed in-window reads (stats build only)
//   wr_count     accepted writes (stats build only)
module sram_responder #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 24,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0,
   parameter int READ_LAT  = 2
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              read_enable,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] w_data,
   input  logic              mem_clr,
   output logic [DATA_W-1:0] r_data,
   output logic              r_valid,
   output logic              busy,
   output logic              error,
   output logic              err_sticky,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             error_q, err_sticky_q;

   // ---------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------
   logic [ADDR_W-1:0] offset;
   logic [IDX_W-1:0]  mem_idx;
   logic              in_window, busy_now, clr_acc, req_err;
   logic              rd_req, rd_ok, wr_ok;

   assign offset  = address - BASE_A;
   assign mem_idx = offset[IDX_W-1:0];
   // The lower bound is checked on the raw address, so the subtraction can
   // never wrap an address below the window back into it. The upper bound
   // uses one extra bit, so a window that would run past the top of the
   // address space does not wrap around to low addresses either.
   assign in_window = (address >= BASE_A) && ({1'b0, offset} < DEPTH_X);

   assign busy_now = (state_q == CLEAR);
   assign clr_acc  = (state_q == IDLE) && mem_clr;
   assign req_err  = (read_enable || write_enable) &&
                     ((read_enable && write_enable) || !in_window || busy_now || clr_acc);
   assign rd_req   = read_enable && !write_enable;
   assign rd_ok    = rd_req && !req_err;
   assign wr_ok    = write_enable && !read_enable && !req_err;

   // ---------------------------------------------------------------
   // Clear sequencer
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (mem_clr) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(DEPTH - 1)) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         error_q      <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         error_q <= req_err;
         if (req_err) begin
            err_sticky_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Storage: one write port shared by the sequencer and the bus, and a
   // registered read port. Both are kept free of reset so they map onto
   // block RAM.
   // ---------------------------------------------------------------
   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // Gating with n_rst keeps bus traffic from landing in the array while
   // reset is held.
   assign mem_we    = n_rst && (busy_now || wr_ok);
   assign mem_waddr = busy_now ? idx_q : mem_idx;
   assign mem_wdata = busy_now ? '0 : w_data;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // ---------------------------------------------------------------
   // Read pipeline. Every read-only request occupies a slot, even a
   // rejected one, so the requester always gets one response per read.
   // ok marks slots whose data is real; the rest return zero.
   // ---------------------------------------------------------------
   logic [READ_LAT-1:0] v_q, v_d, ok_q, ok_d;
   logic [DATA_W-1:0]   d_q [READ_LAT];

   assign v_d[0]  = rd_req;
   assign ok_d[0] = rd_ok;

   for (genvar gi = 1; gi < READ_LAT; gi++) begin : g_rd_stage
      assign v_d[gi]  = v_q[gi-1];
      assign ok_d[gi] = ok_q[gi-1];
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         v_q  <= '0;
         ok_q <= '0;
      end else begin
         v_q  <= v_d;
         ok_q <= ok_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_ok) begin
         d_q[0] <= mem[mem_idx];
      end
      for (int i = 1; i < READ_LAT; i++) begin
         d_q[i] <= d_q[i-1];
      end
   end

   assign r_valid    = v_q[READ_LAT-1];
   assign r_data     = ok_q[READ_LAT-1] ? d_q[READ_LAT-1] : '0;
   assign busy       = busy_now;
   assign error      = error_q;
   assign err_sticky = err_sticky_q;

   // ---------------------------------------------------------------
   // Optional statistics
   // ---------------------------------------------------------------
`ifdef SRAM_RESP_STATS_EN
   logic [READ_LAT-1:0] win_q, win_d;
   logic [15:0]         rd_cnt_q, wr_cnt_q;

   assign win_d[0] = rd_req && in_window;
   for (genvar gi = 1; gi < READ_LAT; gi++) begin : g_win_stage
      assign win_d[gi] = win_q[gi-1];
   end

   // Counting as a slot enters the last stage makes rd_count step in the
   // same cycle that its r_valid appears.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         win_q    <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         win_q <= win_d;
         if (v_d[READ_LAT-1] && win_d[READ_LAT-1] && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_q <= rd_cnt_q + 16'd1;
         end
         if (wr_ok && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
         end
      end
   end

   assign rd_count = rd_cnt_q;
   assign wr_count = wr_cnt_q;
`else
   assign rd_count = '0;
   assign wr_count = '0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder. Directed scenarios are followed by random
// traffic. Each cycle, every output is compared against a reference model
// kept inside the bench.
module tb_sram_responder;

   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 24;
   localparam int DEPTH     = 256;
   localparam int BASE_ADDR = 0;
   localparam int READ_LAT  = 2;
   localparam int RING      = 8;

   logic              clk = 1'b0;
   logic              n_rst = 1'b0;
   logic              read_enable = 1'b0;
   logic              write_enable = 1'b0;
   logic [ADDR_W-1:0] address = '0;
   logic [DATA_W-1:0] w_data = '0;
   logic              mem_clr = 1'b0;
   logic [DATA_W-1:0] r_data;
   logic              r_valid, busy, error, err_sticky;
   logic [15:0]       rd_count, wr_count;

   sram_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
      .BASE_ADDR(BASE_ADDR), .READ_LAT(READ_LAT)
   ) dut (
      .clk(clk), .n_rst(n_rst), .read_enable(read_enable),
      .write_enable(write_enable), .address(address), .w_data(w_data),
      .mem_clr(mem_clr), .r_data(r_data), .r_valid(r_valid), .busy(busy),
      .error(error), .err_sticky(err_sticky), .rd_count(rd_count),
      .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: the array contents, known-ness, and a schedule of
   // responses keyed by the clock edge at which they become visible.
   logic [DATA_W-1:0] m_mem [DEPTH];
   bit                m_known [DEPTH];
   int                m_busy_left = 0;
   bit                m_sticky = 0;
   int                m_rd_cnt = 0;
   int                m_wr_cnt = 0;
   int                m_edge = 0;
   bit                ring_v [RING];
   bit                ring_win [RING];
   bit                ring_known [RING];
   logic [DATA_W-1:0] ring_d [RING];

   task automatic model_reset();
      m_busy_left = 0;
      m_sticky = 0;
      m_rd_cnt = 0;
      m_wr_cnt = 0;
      for (int i = 0; i < RING; i++) begin
         ring_v[i] = 0; ring_win[i] = 0; ring_known[i] = 0; ring_d[i] = '0;
      end
      for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_r_valid"}, 32'(r_valid), 32'd0);
      check_eq({tag, "_r_data"}, 32'(r_data), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_error"}, 32'(error), 32'd0);
      check_eq({tag, "_sticky"}, 32'(err_sticky), 32'd0);
      check_eq({tag, "_rd_count"}, 32'(rd_count), 32'd0);
      check_eq({tag, "_wr_count"}, 32'(wr_count), 32'd0);
   endtask

   // One bus cycle: drive at the falling edge, let the rising edge happen,
   // advance the model, and check every output at the next falling edge.
   task automatic step(input bit re, input bit we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit clr);
      bit  busy_before, clr_acc, in_win, e, exp_v, exp_k;
      int  slot, cur, off;
      logic [DATA_W-1:0] exp_d;
      read_enable = re; write_enable = we; address = a; w_data = d; mem_clr = clr;
      @(posedge clk);
      busy_before = (m_busy_left > 0);
      clr_acc = clr && !busy_before;
      in_win = (int'(a) >= BASE_ADDR) && (int'(a) < BASE_ADDR + DEPTH);
      off = int'(a) - BASE_ADDR;
      e = (re || we) && ((re && we) || !in_win || busy_before || clr_acc);
      if (re && !we) begin
         slot = (m_edge + READ_LAT - 1) % RING;
         ring_v[slot] = 1;
         ring_win[slot] = in_win;
         ring_d[slot] = e ? '0 : m_mem[off];
         ring_known[slot] = e ? 1'b1 : m_known[off];
      end
      if (we && !re && !e) begin
         m_mem[off] = d;
         m_known[off] = 1;
         if (m_wr_cnt < 65535) m_wr_cnt++;
      end
      if (busy_before) m_busy_left--;
      else if (clr) begin
         m_busy_left = DEPTH;
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0; m_known[i] = 1;
         end
      end
      if (e) m_sticky = 1;
      cur = m_edge % RING;
      exp_v = ring_v[cur];
      exp_k = ring_known[cur];
      exp_d = exp_v ? ring_d[cur] : '0;
      if (exp_v && ring_win[cur] && m_rd_cnt < 65535) m_rd_cnt++;
      ring_v[cur] = 0;
      m_edge++;
      @(negedge clk);
      $display("cyc %0d re=%0b we=%0b clr=%0b addr=%h wd=%h | r_valid=%0b r_data=%h err=%0b busy=%0b",
               m_edge, re, we, clr, a, d, r_valid, r_data, error, busy);
      check_eq("r_valid", 32'(r_valid), 32'(exp_v));
      if (!exp_v || exp_k) check_eq("r_data", 32'(r_data), 32'(exp_d));
      check_eq("error", 32'(error), 32'(e));
      check_eq("err_sticky", 32'(err_sticky), 32'(m_sticky));
      check_eq("busy", 32'(busy), 32'(m_busy_left > 0));
`ifdef SRAM_RESP_STATS_EN
      check_eq("rd_count", 32'(rd_count), 32'(m_rd_cnt));
      check_eq("wr_count", 32'(wr_count), 32'(m_wr_cnt));
`else
      check_eq("rd_count", 32'(rd_count), 32'd0);
      check_eq("wr_count", 32'(wr_count), 32'd0);
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0);
   endtask

   initial begin
      int r;
      logic [ADDR_W-1:0] a;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      n_rst = 1'b1;

      // Write then read the same address on the next cycle.
      step(0, 1, 16'h0005, 24'hFAFEAB, 0);
      step(1, 0, 16'h0005, '0, 0);
      idle(3);

      // Back-to-back reads of a preloaded block.
      step(0, 1, 16'h0000, 24'h000011, 0);
      step(0, 1, 16'h0001, 24'h000022, 0);
      step(0, 1, 16'h0002, 24'h000033, 0);
      step(0, 1, 16'h0003, 24'h000044, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 16'(i), '0, 0);
      idle(3);

      // Both enables high: error and no response; the word is left intact.
      step(0, 1, 16'h0010, 24'h123456, 0);
      step(1, 1, 16'h0010, 24'hDEAD00, 0);
      idle(2);
      step(1, 0, 16'h0010, '0, 0);
      idle(3);

      // Out-of-window reads and writes, including the top of the address space.
      step(1, 0, 16'h0100, '0, 0);
      step(0, 1, 16'hFFFF, 24'h0000AA, 0);
      idle(3);

      // Clear, a write that lands while busy, then the last word reads zero.
      step(0, 0, '0, '0, 1);
      idle(2);
      step(0, 1, 16'h00FF, 24'hABCDEF, 0);
      idle(DEPTH);
      step(1, 0, 16'h00FF, '0, 0);
      step(1, 0, 16'h0005, '0, 0);
      idle(3);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         r = int'($urandom_range(0, 199));
         a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
         if (r < 80)       step(1, 0, a, '0, 0);
         else if (r < 150) step(0, 1, a, 24'($urandom), 0);
         else if (r < 158) step(1, 1, a, 24'($urandom), 0);
         else if (r < 160) step(0, 0, '0, '0, 1);
         else              step(0, 0, '0, '0, 0);
      end
      idle(DEPTH + 4);

      // Reset pulsed right after a read edge discards the pending response.
      step(1, 0, 16'h0003, '0, 0);
      n_rst = 1'b0;
      read_enable = 1'b0;
      #1;
      check_idle_outputs("midread_rst");
      @(posedge clk);
      @(negedge clk);
      model_reset();
      m_edge++;
      n_rst = 1'b1;
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
Synthesizable responder for the SRAM-style bus that pixelcontroller drives: read_enable, write_enable, 16-bit address, 24-bit w_data/r_data.
- Serves requests from an internal register array mapped at a fixed address window.
- Returns read data after a fixed pipelined latency.
- Provides a multi-cycle clear sequencer and protocol error flagging.
- Stands in for off-chip SRAM in on-chip image buffering and gives pixelcontroller a cycle-accurate target.

Parameters:
- ADDR_W, 16: bus address width.
- DATA_W, 24: word width (one RGB pixel).
- DEPTH, 256: number of words stored; power of two.
- BASE_ADDR, 0: first bus address served; window is BASE_ADDR..BASE_ADDR+DEPTH-1.
- READ_LAT, 2: cycles from read sample edge to r_valid; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- read_enable  in  1  read request, sampled each rising edge.
- write_enable  in  1  write request, sampled each rising edge.
- address  in  ADDR_W  request address.
- w_data  in  DATA_W  write data.
- mem_clr  in  1  single-cycle request to zero the whole array.
- r_data  out  DATA_W  read data; 0 whenever r_valid=0.
- r_valid  out  1  one-cycle strobe per completed read.
- busy  out  1  high while the clear sequencer runs.
- error  out  1  one-cycle pulse per rejected or faulty access.
- err_sticky  out  1  latched error; cleared only by reset.
- rd_count  out  16  completed reads (see Optional Feature).
- wr_count  out  16  completed writes (see Optional Feature).

Behaviour:
- Reset (async, n_rst=0): all outputs 0, read pipeline emptied, FSM to IDLE, counters 0.
- Array contents are not reset; they are undefined until written or cleared.
- Reset mid-clear or mid-read aborts the operation; in-flight reads are discarded with no r_valid.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on mem_clr=1 at an edge. idx=0, busy=1 from the next cycle.
  - CLEAR: writes 0 to mem[idx] each cycle, idx++. Leaves for IDLE after idx=DEPTH-1 is written, so the clear takes exactly DEPTH cycles.
  - busy drops in the first IDLE cycle.
  - mem_clr while in CLEAR is ignored and does not restart the sequence.
- Request rules, IDLE only:
  - Write (write_enable=1, read_enable=0, address in window): mem[address-BASE_ADDR] <= w_data at that edge.
  - Read (read_enable=1, write_enable=0, address in window): array sampled at that edge. r_data/r_valid appear READ_LAT cycles later.
  - Back-to-back reads every cycle are supported, with one r_valid per read and order preserved.
  - A read in the cycle after a write to the same address returns the new data.
- Error cases, each producing error=1 the cycle after the offending edge, err_sticky=1, and no array modification:
  - both enables high;
  - address outside the window;
  - any request while busy=1 or in the same edge as an accepted mem_clr.
- Errored reads still produce r_valid after READ_LAT with r_data=0, so the requester always sees one response per read. Both-high requests produce no r_valid.
- Address arithmetic: offset = address - BASE_ADDR, ADDR_W-bit unsigned. The window check must not wrap when BASE_ADDR+DEPTH exceeds 2^ADDR_W; those addresses are out of range.
- Idle bus (both enables low): no action, no error.

Optional Feature:
- Macro: SRAM_RESP_STATS_EN.
- Defined:
  - rd_count increments on each r_valid whose read was in-window.
  - wr_count increments on each accepted write.
  - Both are 16-bit and saturate at 16'hFFFF.
- Undefined: rd_count and wr_count are tied to 0 and no counter flops exist.

Test Plan:
- Reset, then write 24'hFAFEAB to address 0x0005, then read 0x0005 -> r_valid exactly 2 cycles after the read edge with r_data=24'hFAFEAB; error stays 0.
- Reads on 4 consecutive cycles from 0x00..0x03 preloaded with 0x11,0x22,0x33,0x44 -> r_valid high for 4 consecutive cycles, data in the same order.
- read_enable and write_enable both high at 0x0010 -> error pulse next cycle, err_sticky=1, no r_valid, mem[0x10] unchanged.
- Read from 0x0100 with DEPTH=256, BASE_ADDR=0 -> error pulse, then r_valid with r_data=0.
- mem_clr, then a write issued 3 cycles later -> busy high for 256 cycles, the write errors, and reading 0x00FF after busy drops returns 0.
- n_rst pulsed low one cycle after a read edge -> no r_valid, all outputs 0.
- With SRAM_RESP_STATS_EN: 3 writes and 2 reads -> wr_count=3, rd_count=2.
